// File: rtl/mc_control_fsm_pkg.sv
// Shared MIPS declarations: opcodes, funct codes, FSM state and ALU-op encodings,
// plus the per-state control decode used by the multicycle controller.
package mips_decls_p;

  typedef enum logic [5:0] {
    RTYPE = 6'b000000,
    J     = 6'b000010,
    BEQ   = 6'b000100,
    BNE   = 6'b000101,
    ADDI  = 6'b001000,
    ORI   = 6'b001101,
    LW    = 6'b100011,
    SW    = 6'b101011
  } opcode_t;

  typedef logic [5:0] funct_t;
  localparam funct_t F_ADD = 6'b100000;
  localparam funct_t F_SUB = 6'b100010;
  localparam funct_t F_AND = 6'b100100;
  localparam funct_t F_OR  = 6'b100101;
  localparam funct_t F_SLT = 6'b101010;

  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE,
    ALUWB, BRANCH, IEXEC, IWB, JUMP, HALT
  } statetype_t;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_OR} aluop_t;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       sign;
    logic       illegal;
    logic       pcwrite;
    logic       branch;
    logic       branchne;
    aluop_t     aluop;
  } ctrl_t;

  // Moore decode; op only matters for states whose action depends on the instruction.
  function automatic ctrl_t ctrl_decode(statetype_t s, opcode_t op);
    ctrl_t c;
    c       = '0;
    c.sign  = 1'b1;
    c.aluop = ALU_ADD;
    case (s)
      FETCH:   begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:   c.iord = 1'b1;
      MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      EXECUTE: begin c.alusrca = 1'b1; c.aluop = ALU_FUNCT; end
      ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      BRANCH: begin
        c.alusrca  = 1'b1;
        c.aluop    = ALU_SUB;
        c.pcsrc    = 2'b01;
        c.branch   = (op == BEQ);
        c.branchne = (op == BNE);
      end
      IEXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        if (op == ORI) begin
          c.aluop = ALU_OR;
          c.sign  = 1'b0;
        end
      end
      IWB:     c.regwrite = 1'b1;
      JUMP:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      HALT:    c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_control_fsm_aludec.sv
// ALU decoder: maps the controller's aluop (and funct for R-type) to the ALU op code.
module aludec
  import mips_decls_p::*;
(
  input  aluop_t     aluop,
  input  funct_t     funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      ALU_ADD: alucontrol = 3'b010;
      ALU_SUB: alucontrol = 3'b110;
      ALU_OR:  alucontrol = 3'b001;
      default: begin
        case (funct)
          F_ADD:   alucontrol = 3'b010;
          F_SUB:   alucontrol = 3'b110;
          F_AND:   alucontrol = 3'b000;
          F_OR:    alucontrol = 3'b001;
          F_SLT:   alucontrol = 3'b111;
          default: alucontrol = 3'b010;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle main controller: one state per clock, controls registered from the
// next-state decode so they always reflect the current state without glitches.
module mc_control_fsm
  import mips_decls_p::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  opcode_t    opcode,
  input  funct_t     funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       sign,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  statetype_t st, nst;
  ctrl_t      ctl;

  always_comb begin
    nst = FETCH;
    case (st)
      FETCH:  nst = DECODE;
      DECODE: begin
        case (opcode)
          LW, SW:    nst = MEMADR;
          RTYPE:     nst = EXECUTE;
          BEQ, BNE:  nst = BRANCH;
          ADDI, ORI: nst = IEXEC;
          J:         nst = JUMP;
          default:   nst = TRAP_ON_ILLEGAL ? HALT : FETCH;
        endcase
      end
      MEMADR:  nst = (opcode == LW) ? MEMRD : MEMWR;
      MEMRD:   nst = MEMWB;
      EXECUTE: nst = ALUWB;
      IEXEC:   nst = IWB;
      HALT:    nst = HALT;
      default: nst = FETCH;
    endcase
  end

  // Outputs register alongside the state so reset immediately presents FETCH controls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st  <= FETCH;
      ctl <= ctrl_decode(FETCH, opcode);
    end else begin
      st  <= nst;
      ctl <= ctrl_decode(nst, opcode);
    end
  end

  aludec u_aludec (
    .aluop      (ctl.aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  // Only registered terms gate zero, so pcen cannot rise outside FETCH/JUMP/BRANCH.
  assign pcen     = ctl.pcwrite | (ctl.branch & zero) | (ctl.branchne & ~zero);
  assign iord     = ctl.iord;
  assign irwrite  = ctl.irwrite;
  assign memwrite = ctl.memwrite;
  assign regwrite = ctl.regwrite;
  assign regdst   = ctl.regdst;
  assign memtoreg = ctl.memtoreg;
  assign alusrca  = ctl.alusrca;
  assign alusrcb  = ctl.alusrcb;
  assign pcsrc    = ctl.pcsrc;
  assign sign     = ctl.sign;
  assign illegal  = ctl.illegal;
  assign state    = st;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench: stimulus pushes the expected per-cycle controls, a negedge
// monitor pops and compares. Two instances cover both illegal-opcode policies.
module tb_mc_control_fsm;
  import mips_decls_p::*;

  typedef struct packed {
    logic [3:0] state;
    logic       pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       sign;
    logic [2:0] alucontrol;
    logic       illegal;
  } outs_t;

  typedef struct {
    string tag;
    outs_t e;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic    reset = 1'b1, reset2 = 1'b1;
  opcode_t opcode = LW, opcode2 = LW;
  funct_t  funct = F_ADD;
  logic    zero = 1'b0, zero2 = 1'b0;

  logic       pcen1, iord1, irwrite1, memwrite1, regwrite1, regdst1, memtoreg1, alusrca1, sign1, illegal1;
  logic [1:0] alusrcb1, pcsrc1;
  logic [2:0] alucontrol1;
  logic [3:0] state1;
  logic       pcen2, iord2, irwrite2, memwrite2, regwrite2, regdst2, memtoreg2, alusrca2, sign2, illegal2;
  logic [1:0] alusrcb2, pcsrc2;
  logic [2:0] alucontrol2;
  logic [3:0] state2;

  mc_control_fsm #(.TRAP_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pcen(pcen1), .iord(iord1), .irwrite(irwrite1), .memwrite(memwrite1),
    .regwrite(regwrite1), .regdst(regdst1), .memtoreg(memtoreg1), .alusrca(alusrca1),
    .alusrcb(alusrcb1), .pcsrc(pcsrc1), .sign(sign1), .alucontrol(alucontrol1),
    .illegal(illegal1), .state(state1)
  );

  mc_control_fsm #(.TRAP_ON_ILLEGAL(1'b1)) dut_trap (
    .clk(clk), .reset(reset2), .opcode(opcode2), .funct(funct), .zero(zero2),
    .pcen(pcen2), .iord(iord2), .irwrite(irwrite2), .memwrite(memwrite2),
    .regwrite(regwrite2), .regdst(regdst2), .memtoreg(memtoreg2), .alusrca(alusrca2),
    .alusrcb(alusrcb2), .pcsrc(pcsrc2), .sign(sign2), .alucontrol(alucontrol2),
    .illegal(illegal2), .state(state2)
  );

  outs_t act1, act2;
  assign act1 = {state1, pcen1, iord1, irwrite1, memwrite1, regwrite1, regdst1, memtoreg1,
                 alusrca1, alusrcb1, pcsrc1, sign1, alucontrol1, illegal1};
  assign act2 = {state2, pcen2, iord2, irwrite2, memwrite2, regwrite2, regdst2, memtoreg2,
                 alusrca2, alusrcb2, pcsrc2, sign2, alucontrol2, illegal2};

  exp_t q1[$], q2[$];
  int   n_cmp = 0, n_bad = 0;

  // Expected controls per state, written out from the state action table.
  function automatic outs_t exp_of(statetype_t s, opcode_t op, funct_t fn, logic z);
    outs_t e;
    e = '0;
    e.state = s;
    e.sign = 1'b1;
    e.alucontrol = 3'b010;
    case (s)
      FETCH:   begin e.alusrcb = 2'b01; e.irwrite = 1'b1; e.pcen = 1'b1; end
      DECODE:  e.alusrcb = 2'b11;
      MEMADR:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      MEMRD:   e.iord = 1'b1;
      MEMWB:   begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
      MEMWR:   begin e.iord = 1'b1; e.memwrite = 1'b1; end
      EXECUTE: begin
        e.alusrca = 1'b1;
        e.alucontrol = (fn == F_SLT) ? 3'b111 : (fn == F_SUB) ? 3'b110 :
                       (fn == F_AND) ? 3'b000 : (fn == F_OR) ? 3'b001 : 3'b010;
      end
      ALUWB:   begin e.regdst = 1'b1; e.regwrite = 1'b1; end
      BRANCH: begin
        e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01;
        e.pcen = (op == BEQ) ? z : ~z;
      end
      IEXEC: begin
        e.alusrca = 1'b1; e.alusrcb = 2'b10;
        if (op == ORI) begin e.sign = 1'b0; e.alucontrol = 3'b001; end
      end
      IWB:     e.regwrite = 1'b1;
      JUMP:    begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      HALT:    e.illegal = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic push(input int sel, input string tag, input statetype_t s,
                      input opcode_t op, input funct_t fn, input logic z);
    exp_t r;
    r.tag = tag;
    r.e = exp_of(s, op, fn, z);
    if (sel == 0) q1.push_back(r);
    else q2.push_back(r);
  endtask

  // One slot per clock; slot 0 is the FETCH cycle (optionally releasing reset).
  task automatic do_instr(input int sel, input bit rel, input string tag, input opcode_t op,
                          input funct_t fn, input logic z, input int n, input statetype_t seq[8]);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        funct = fn;
        if (sel == 0) begin opcode = op; if (rel) reset = 1'b0; end
        else begin opcode2 = op; if (rel) reset2 = 1'b0; end
      end
      if (sel == 0) zero = z; else zero2 = z;
      push(sel, tag, seq[i], op, fn, z);
    end
  endtask

  always @(negedge clk) begin
    exp_t r;
    if (q1.size() != 0) begin
      r = q1.pop_front();
      n_cmp++;
      if (act1 !== r.e) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", r.tag, act1, r.e);
      end
    end
    if (q2.size() != 0) begin
      r = q2.pop_front();
      n_cmp++;
      if (act2 !== r.e) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", r.tag, act2, r.e);
      end
    end
  end

  opcode_t bad_op;

  initial begin
    bad_op = opcode_t'(6'b111111);
    @(posedge clk); #1; push(0, "rst_hold", FETCH, LW, F_ADD, 1'b0);
    @(posedge clk); #1; push(0, "rst_hold2", FETCH, LW, F_ADD, 1'b0);

    do_instr(0, 1, "lw",     LW,    F_ADD, 1'b0, 5, '{FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH, FETCH, FETCH});
    do_instr(0, 0, "sw",     SW,    F_ADD, 1'b0, 4, '{FETCH, DECODE, MEMADR, MEMWR, FETCH, FETCH, FETCH, FETCH});
    do_instr(0, 0, "beq_z1", BEQ,   F_ADD, 1'b1, 3, '{FETCH, DECODE, BRANCH, FETCH, FETCH, FETCH, FETCH, FETCH});
    do_instr(0, 0, "beq_z0", BEQ,   F_ADD, 1'b0, 3, '{FETCH, DECODE, BRANCH, FETCH, FETCH, FETCH, FETCH, FETCH});
    do_instr(0, 0, "bne_z0", BNE,   F_ADD, 1'b0, 3, '{FETCH, DECODE, BRANCH, FETCH, FETCH, FETCH, FETCH, FETCH});
    do_instr(0, 0, "bne_z1", BNE,   F_ADD, 1'b1, 3, '{FETCH, DECODE, BRANCH, FETCH, FETCH, FETCH, FETCH, FETCH});
    do_instr(0, 0, "ori",    ORI,   F_ADD, 1'b0, 4, '{FETCH, DECODE, IEXEC, IWB, FETCH, FETCH, FETCH, FETCH});
    do_instr(0, 0, "addi",   ADDI,  F_ADD, 1'b0, 4, '{FETCH, DECODE, IEXEC, IWB, FETCH, FETCH, FETCH, FETCH});
    do_instr(0, 0, "slt",    RTYPE, F_SLT, 1'b0, 4, '{FETCH, DECODE, EXECUTE, ALUWB, FETCH, FETCH, FETCH, FETCH});
    do_instr(0, 0, "sub",    RTYPE, F_SUB, 1'b0, 4, '{FETCH, DECODE, EXECUTE, ALUWB, FETCH, FETCH, FETCH, FETCH});
    do_instr(0, 0, "j",      J,     F_ADD, 1'b0, 3, '{FETCH, DECODE, JUMP, FETCH, FETCH, FETCH, FETCH, FETCH});
    do_instr(0, 0, "skip",   bad_op, F_ADD, 1'b0, 2, '{FETCH, DECODE, FETCH, FETCH, FETCH, FETCH, FETCH, FETCH});

    // Abort a load while it sits in MEMRD.
    do_instr(0, 0, "lw_abort", LW, F_ADD, 1'b0, 3, '{FETCH, DECODE, MEMADR, FETCH, FETCH, FETCH, FETCH, FETCH});
    @(posedge clk); #1; reset = 1'b1; push(0, "rst_mid", FETCH, LW, F_ADD, 1'b0);
    @(posedge clk); #1; push(0, "rst_mid2", FETCH, LW, F_ADD, 1'b0);
    do_instr(0, 1, "j_after", J,  F_ADD, 1'b0, 3, '{FETCH, DECODE, JUMP, FETCH, FETCH, FETCH, FETCH, FETCH});
    do_instr(0, 0, "lw_again", LW, F_ADD, 1'b0, 5, '{FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH, FETCH, FETCH});

    // Trapping instance: illegal opcode parks in HALT until reset.
    do_instr(1, 1, "trap", bad_op, F_ADD, 1'b0, 2, '{FETCH, DECODE, FETCH, FETCH, FETCH, FETCH, FETCH, FETCH});
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1; push(1, "halt", HALT, bad_op, F_ADD, 1'b0);
    end
    @(posedge clk); #1; reset2 = 1'b1; push(1, "halt_rst", FETCH, bad_op, F_ADD, 1'b0);
    do_instr(1, 1, "trap_rec", J, F_ADD, 1'b0, 3, '{FETCH, DECODE, JUMP, FETCH, FETCH, FETCH, FETCH, FETCH});

    @(posedge clk); @(negedge clk); #1;
    if (q1.size() != 0 || q2.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending %0d/%0d expected 0/0", q1.size(), q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
